// File: rtl/cci_rd_arbiter.sv
// cci_rd_arbiter: round-robin CCI TX0 read arbiter with an mdata tag pool.
// Define CCI_ARB_HAZARD_STALL_EN to hold off reads that hit a live cache line.
module cci_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int DATA_WIDTH = 512
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_c0_almostfull,
    output logic                          tx_c0_rdvalid,
    output logic [ADDR_WIDTH-1:0]         tx_c0_addr,
    output logic [TAG_WIDTH-1:0]          tx_c0_tag,
    input  logic                          rx_c0_rdvalid,
    input  logic [TAG_WIDTH-1:0]          rx_c0_tag,
    input  logic [DATA_WIDTH-1:0]         rx_c0_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [TAG_WIDTH:0]            outstanding,
    output logic                          err_spurious,
    output logic                          hazard_stall
);
    localparam int NTAGS = 2 ** TAG_WIDTH;
    localparam int IW    = $clog2(NUM_REQ);

    logic [NTAGS-1:0]      live;
    logic [IW-1:0]         tag_owner [NTAGS];
    logic [IW-1:0]         rr_ptr;
    logic [NUM_REQ-1:0]    haz;
    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    rsp_sel;
    logic                  any_free;
    logic                  gnt_found;
    logic                  rsp_hit;
    logic [IW-1:0]         gnt_idx;
    logic [TAG_WIDTH-1:0]  free_tag;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [NTAGS-1:0]      alloc_mask;
    logic [NTAGS-1:0]      free_mask;

    assign any_free = ~&live;
    assign elig     = req_valid & ~haz
                    & {NUM_REQ{any_free && !tx_c0_almostfull && !reset}};
    assign rsp_hit  = rx_c0_rdvalid && live[rx_c0_tag];
    assign gnt_addr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    // Round-robin search starting at rr_ptr, wrapping past NUM_REQ-1
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_found && elig[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        free_tag = '0;
        for (int t = NTAGS - 1; t >= 0; t--)
            if (!live[t]) free_tag = TAG_WIDTH'(t);
    end

    always_comb begin
        rsp_sel = '0;
        rsp_sel[tag_owner[rx_c0_tag]] = 1'b1;
    end

    assign alloc_mask = gnt_found ? (NTAGS'(1) << free_tag) : '0;
    assign free_mask  = rsp_hit ? (NTAGS'(1) << rx_c0_tag) : '0;

    always_ff @(posedge clk) begin
        if (gnt_found) tag_owner[free_tag] <= gnt_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live          <= '0;
            rr_ptr        <= '0;
            tx_c0_rdvalid <= 1'b0;
            tx_c0_addr    <= '0;
            tx_c0_tag     <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            outstanding   <= '0;
            err_spurious  <= 1'b0;
        end else begin
            tx_c0_rdvalid <= gnt_found;
            rsp_valid     <= '0;
            if (gnt_found) begin
                tx_c0_addr <= gnt_addr;
                tx_c0_tag  <= free_tag;
                rr_ptr     <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            end
            if (rsp_hit) begin
                rsp_valid <= rsp_sel;
                rsp_data  <= rx_c0_data;
            end else if (rx_c0_rdvalid) begin
                err_spurious <= 1'b1;
            end
            // A tag freed here only becomes allocatable next cycle
            live <= (live | alloc_mask) & ~free_mask;
            case ({gnt_found, rsp_hit})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef CCI_ARB_HAZARD_STALL_EN
    logic [ADDR_WIDTH-1:0] tag_addr [NTAGS];

    always_ff @(posedge clk) begin
        if (gnt_found) tag_addr[free_tag] <= gnt_addr;
    end

    always_comb begin
        haz = '0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int t = 0; t < NTAGS; t++)
                if (live[t] && tag_addr[t] == req_addr[i*ADDR_WIDTH +: ADDR_WIDTH])
                    haz[i] = 1'b1;
    end

    assign hazard_stall = !reset && |(req_valid & haz);
`else
    assign haz          = '0;
    assign hazard_stall = 1'b0;
`endif

endmodule

// File: doc/cci_rd_arbiter.md
Name: cci_rd_arbiter

Overview:
Shares the CCI TX channel-0 read path between NUM_REQ AFU-side requesters using round-robin arbitration. Allocates a unique mdata tag per issued read and routes RX channel-0 read responses back to the owning requester by tag. Sits between AFU engines and the CCI TX0/RX0 ports, upstream of the CCI sniffer. Optionally stalls same-cache-line reads so the sniffer never flags a read-read hazard.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, cache-line address width
TAG_WIDTH, 5, mdata tag width; tag pool size NTAGS = 2**TAG_WIDTH
DATA_WIDTH, 512, cache-line data width

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_WIDTH  packed CL addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  out  NUM_REQ  one-hot grant; request accepted when req_valid[i] && req_ready[i]
tx_c0_almostfull  in  1  CCI TX0 backpressure
tx_c0_rdvalid  out  1  read issue strobe
tx_c0_addr  out  ADDR_WIDTH  issued CL address
tx_c0_tag  out  TAG_WIDTH  issued mdata tag
rx_c0_rdvalid  in  1  read response strobe
rx_c0_tag  in  TAG_WIDTH  response mdata tag
rx_c0_data  in  DATA_WIDTH  response data
rsp_valid  out  NUM_REQ  one-hot response strobe to owner
rsp_data  out  DATA_WIDTH  response data (shared bus)
outstanding  out  TAG_WIDTH+1  count of allocated tags
err_spurious  out  1  sticky: response arrived on an unallocated tag
hazard_stall  out  1  a valid requester was masked this cycle for an address hazard

Behaviour:
- Reset, held one or more cycles: req_ready=0, tx_c0_rdvalid=0, tx_c0_addr=0, tx_c0_tag=0, rsp_valid=0, rsp_data=0, outstanding=0, err_spurious=0, hazard_stall=0. All tags free, RR pointer=0.
- Reset mid-operation discards every in-flight tag. Later responses to those tags set err_spurious.
- Eligibility: req_valid[i], plus at least one free tag, plus tx_c0_almostfull=0.
- Grant: req_ready is combinational. One-hot to the first eligible requester searching from the RR pointer upward, with wrap. All zero if no tag is free or almostfull=1.
- On accept: pointer <= granted index+1 mod NUM_REQ. Pointer is unchanged when nothing is granted.
- Tag allocation: lowest-index free tag from the current-cycle free bitmap. Store {owner id, addr} in the tag table.
- Issue latency: 1 cycle. tx_c0_rdvalid/addr/tag are registered from the accepted request. tx_c0_rdvalid is 1 for exactly one cycle per accept. addr/tag hold their last value when rdvalid=0.
- Response: rx_c0_rdvalid with an allocated tag sets rsp_valid[owner]=1 for one cycle at T+1, rsp_data <= rx_c0_data, and frees the tag at the same edge.
- Unallocated tag: no rsp_valid, bitmap unchanged, err_spurious <= 1. Cleared only by reset.
- Same-cycle allocate and free: a tag freed this cycle is not allocatable until the next cycle. outstanding nets +1-1 = unchanged.
- outstanding saturates naturally at NTAGS. When it equals NTAGS, req_ready=0 even though almostfull=0.
- Responses are accepted every cycle regardless of almostfull. There is no backpressure on rsp_valid.

Optional Feature:
CCI_ARB_HAZARD_STALL_EN
- Defined: requester i is masked from eligibility if req_addr[i] equals the stored addr of any allocated tag. hazard_stall=1 in any cycle where a req_valid requester is so masked.
- Two requesters presenting the same address in one cycle are both eligible; only one can be granted per cycle, and the loser is masked next cycle.
- Not defined: no address compare. hazard_stall is tied to 0. Duplicate in-flight addresses are allowed, and the sniffer reports them.

Test Plan:
- Reset check: reset=1 for 3 cycles while req_valid=4'b1111 -> req_ready=0, tx_c0_rdvalid=0, outstanding=0.
- RR fairness: reset=0, req_valid=4'b1111 held, responses off -> grants 0,1,2,3,0 on consecutive cycles; tx_c0_tag 0,1,2,3,4; outstanding reaches 5.
- Backpressure: tx_c0_almostfull=1 for 4 cycles with req_valid=4'b0010 -> no grants and no tx_c0_rdvalid. Grant to requester 1 on the cycle almostfull drops; rdvalid follows 1 cycle later.
- Tag exhaustion and reuse: issue 32 reads, then rx_c0_rdvalid tag=7 in the same cycle req_valid=1 -> no grant that cycle; next cycle grant gets tag 7; outstanding stays 32→31→32.
- Response routing: requester 2 issues addr 0x1000 (tag 0); rx_c0_rdvalid tag=0, data=0xA5.. -> rsp_valid=4'b0100 for one cycle at T+1 with rsp_data=0xA5..
- Spurious response plus hazard: rx_c0_rdvalid tag=20 unallocated -> err_spurious=1 sticky. With CCI_ARB_HAZARD_STALL_EN, a second request to 0x1000 while tag 0 is live -> hazard_stall=1, no grant until the tag 0 response.
